gfau_arbiter: RTL and testbench
===============================

Name: gfau_arbiter

Overview:
- Shares the single GFAU instance between two independent requesters, for example the point-doubling sequencer and the point-addition sequencer inside Control.
- Accepts one operation at a time using round-robin fairness and latches its operands.
- Drives the GFAU start/done pulse handshake and routes the result back to the owning requester.
- A watchdog aborts any GFAU operation that never signals done.

Parameters:
- SIZE, 32: operand/result width in bits.
- OPW, 2: operation_select width (00 add, 01 sub, 10 mont_mul, 11 inverse).
- TIMEOUT, 1024: max cycles waiting for gfau_done before abort; legal range 2..65535.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_op  in  OPW  requester 0 operation code
- req0_in0  in  SIZE  requester 0 operand A
- req0_in1  in  SIZE  requester 0 operand B
- req0_ready  out  1  requester 0 accepted this cycle
- rsp0_valid  out  1  one-cycle result pulse to requester 0
- rsp0_err  out  1  qualifies rsp0_valid: watchdog abort
- req1_valid/req1_op/req1_in0/req1_in1/req1_ready/rsp1_valid/rsp1_err  same as above, requester 1
- rsp_result  out  SIZE  shared result bus, valid with either rspN_valid
- gfau_start  out  1  one-cycle start pulse (to GFAU_done_from_control)
- gfau_op  out  OPW  to GFAU operation_select
- gfau_in0  out  SIZE  to GFAU in_0
- gfau_in1  out  SIZE  to GFAU in_1
- gfau_done  in  1  GFAU completion pulse (GFAU_done_to_control)
- gfau_result  in  SIZE  GFAU result
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of the last/current granted requester

Behaviour:
- Reset (sampled at posedge i_clk):
  - state goes to IDLE; owner goes to 1, so req0 wins the first contention.
  - All registered outputs go to 0: gfau_start, gfau_op, gfau_in0/1, rsp*, rsp_result, busy.
  - Watchdog counter clears.
  - Reset mid-operation abandons the in-flight op with no response; GFAU shares i_rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; !owner if both.
  - reqN_ready is combinational: high only in IDLE, only for the granted N.
  - On the accept edge: latch op, in0 and in1 into the gfau_* registers; owner <= N; go to ISSUE.
  - No valid: stay in IDLE; ready stays low.
- ISSUE:
  - gfau_start = 1 for exactly this cycle; counter clears; go to WAIT.
- WAIT:
  - gfau_op and gfau_in0/1 are held stable until RESP exits.
  - gfau_done = 1: capture gfau_result into rsp_result; go to RESP.
  - Otherwise the counter increments. If counter == TIMEOUT-1 with no done: rsp_result <= 0, set err flag, go to RESP.
- RESP:
  - rsp[owner]_valid = 1 for one cycle.
  - rsp[owner]_err = err flag; the other requester's rsp stays 0.
  - err flag clears; go to IDLE.
- Latency, when accepted at cycle T:
  - gfau_start high in T+1.
  - If GFAU asserts done in cycle T+1+L (L ≥ 1), rsp_valid is high in T+2+L.
  - Minimum accept-to-next-accept is L+3 cycles.
- Boundary conditions:
  - gfau_done in IDLE, ISSUE or RESP is ignored: no state change, no response. This includes done coincident with start.
  - Requester valid deasserting before ready is allowed; no request is remembered.
  - A requester may hold valid through its own response; it is re-arbitrated in the next IDLE.
  - Both valid continuously: strict alternation 0,1,0,1…
  - Done and timeout in the same cycle: done wins, err = 0.
  - rsp_result holds its last value outside RESP.

Decomposition:
- Shared package ecc_pkg:
  - SIZE
  - op-code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_INV=2'b11
  - FSM state encodings, also reused by Control
- One sub-module, rr_arb2:
  - Purely combinational.
  - Inputs: req0_valid, req1_valid, owner, en. Outputs: one-hot grant, grant index.
- FSM, operand registers and watchdog stay in gfau_arbiter.

Test Plan:
1. Single request: req0 MUL, in0=0x5, in1=0x7, GFAU model L=3. Expect ready0 at T, start at T+1, done at T+4, rsp0_valid with rsp_result=model value at T+5, err0=0, rsp1 silent.
2. Contention after reset: req0 and req1 both valid at T. Expect req0 served first. req1_ready rises the cycle after rsp0_valid; start carries req1 operands.
3. Fairness: both valid for 6 ops. Expect grants 0,1,0,1,0,1; owner toggles each accept; no response lost.
4. Watchdog: TIMEOUT=16, model never asserts done, req1 ADD. Expect rsp1_valid with rsp1_err=1, rsp_result=0, exactly 17 cycles after start; next req then succeeds with err=0.
5. Reset mid-WAIT: i_rst high at start+2. Expect busy=0, no rsp pulse, owner=1 next cycle. A new req0 is accepted in the next IDLE.
6. Spurious done: gfau_done pulsed in IDLE, and again coincident with gfau_start. Expect no state change and no rsp. The op completes only on the later done in WAIT.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared ECC datapath definitions: operand width, GFAU op-codes and sequencer FSM states.
package ecc_pkg;

    localparam int unsigned SIZE = 32;
    localparam int unsigned OPW  = 2;

    localparam logic [OPW-1:0] OP_ADD = 2'b00;
    localparam logic [OPW-1:0] OP_SUB = 2'b01;
    localparam logic [OPW-1:0] OP_MUL = 2'b10;
    localparam logic [OPW-1:0] OP_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } gfau_state_e;

endpackage

// File: rtl/gfau_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not last served wins.
module rr_arb2 (
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic       owner,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_idx = ~owner;
        end else if (req1_valid) begin
            grant_idx = 1'b1;
        end
        grant = 2'b00;
        if (en && (req0_valid || req1_valid)) begin
            grant = {grant_idx, ~grant_idx};
        end
    end

endmodule

// File: rtl/gfau_arbiter.sv
// Shares one GFAU between two requesters: round-robin accept, start/done handshake,
// result routing back to the owner, and a watchdog that aborts a GFAU that never finishes.
module gfau_arbiter #(
    parameter int unsigned SIZE    = ecc_pkg::SIZE,
    parameter int unsigned OPW     = ecc_pkg::OPW,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            req0_valid,
    input  logic [OPW-1:0]  req0_op,
    input  logic [SIZE-1:0] req0_in0,
    input  logic [SIZE-1:0] req0_in1,
    output logic            req0_ready,
    output logic            rsp0_valid,
    output logic            rsp0_err,
    input  logic            req1_valid,
    input  logic [OPW-1:0]  req1_op,
    input  logic [SIZE-1:0] req1_in0,
    input  logic [SIZE-1:0] req1_in1,
    output logic            req1_ready,
    output logic            rsp1_valid,
    output logic            rsp1_err,
    output logic [SIZE-1:0] rsp_result,
    output logic            gfau_start,
    output logic [OPW-1:0]  gfau_op,
    output logic [SIZE-1:0] gfau_in0,
    output logic [SIZE-1:0] gfau_in1,
    input  logic            gfau_done,
    input  logic [SIZE-1:0] gfau_result,
    output logic            busy,
    output logic            owner
);
    import ecc_pkg::*;

    localparam int unsigned    WDW     = 16;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    gfau_state_e     state_q;
    logic [WDW-1:0]  wd_cnt_q;
    logic            owner_q;
    logic            busy_q;
    logic            start_q;
    logic [OPW-1:0]  op_q;
    logic [SIZE-1:0] in0_q;
    logic [SIZE-1:0] in1_q;
    logic [SIZE-1:0] result_q;
    logic            rsp0_valid_q;
    logic            rsp0_err_q;
    logic            rsp1_valid_q;
    logic            rsp1_err_q;

    logic [1:0]      grant;
    logic            grant_idx;

    rr_arb2 u_rr_arb2 (
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .owner      (owner_q),
        .en         (state_q == ST_IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Arbitration FSM, operand latch and watchdog.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wd_cnt_q     <= '0;
            owner_q      <= 1'b1;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            op_q         <= '0;
            in0_q        <= '0;
            in1_q        <= '0;
            result_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        op_q    <= grant_idx ? req1_op  : req0_op;
                        in0_q   <= grant_idx ? req1_in0 : req0_in0;
                        in1_q   <= grant_idx ? req1_in1 : req0_in1;
                        owner_q <= grant_idx;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving in the last watchdog cycle still wins over the abort.
                    if (gfau_done || (wd_cnt_q == WD_LAST)) begin
                        result_q     <= gfau_done ? gfau_result : '0;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <= owner_q;
                        rsp0_err_q   <= ~owner_q & ~gfau_done;
                        rsp1_err_q   <= owner_q & ~gfau_done;
                        state_q      <= ST_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WDW'(1);
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_err   = rsp1_err_q;
    assign rsp_result = result_q;
    assign gfau_start = start_q;
    assign gfau_op    = op_q;
    assign gfau_in0   = in0_q;
    assign gfau_in1   = in1_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_gfau_arbiter.sv
// Bench for gfau_arbiter: directed op table, hand-written corner sequences and random traffic,
// all checked every cycle against a transaction-level model of the arbiter and a GFAU stand-in.
module tb_gfau_arbiter;

    localparam int unsigned SIZE = 32;
    localparam int unsigned OPW  = 2;
    localparam int          TO   = 16;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic [OPW-1:0]  req0_op = '0, req1_op = '0;
    logic [SIZE-1:0] req0_in0 = '0, req0_in1 = '0, req1_in0 = '0, req1_in1 = '0;
    logic            req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [SIZE-1:0] rsp_result;
    logic            gfau_start;
    logic [OPW-1:0]  gfau_op;
    logic [SIZE-1:0] gfau_in0, gfau_in1;
    logic            gfau_done = 1'b0;
    logic [SIZE-1:0] gfau_result = '0;
    logic            busy, owner;

    gfau_arbiter #(.SIZE(SIZE), .OPW(OPW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_in0(req0_in0), .req0_in1(req0_in1),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_in0(req1_in0), .req1_in1(req1_in1),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
        .rsp_result(rsp_result),
        .gfau_start(gfau_start), .gfau_op(gfau_op), .gfau_in0(gfau_in0), .gfau_in1(gfau_in1),
        .gfau_done(gfau_done), .gfau_result(gfau_result),
        .busy(busy), .owner(owner)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } drv_t;

    typedef struct {
        bit          who;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          never;
        logic [31:0] exp_val;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    drv_t drv0, drv1;
    logic rst_drv, rst_prev;
    int   cyc, done_at, g_lat;
    bit   g_never, inject;
    logic [31:0] g_res;
    int   total, bad;

    // transaction-level model state
    bit          m_busy, m_resolved, m_who, m_last, m_err;
    int          m_acc, m_rsp_cyc;
    logic [1:0]  m_op, m_gop;
    logic [31:0] m_a, m_b, m_val, m_res, m_ga, m_gb;

    // observed events
    int          acc_cnt, last_acc_cyc, rsp_cnt, last_rsp_cyc;
    bit          last_acc_who, last_rsp_who, last_rsp_err;
    logic [31:0] last_rsp_val;

    function automatic logic [31:0] gf_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_resolved = 1'b0; m_last = 1'b1; m_res = '0;
        m_gop = '0; m_ga = '0; m_gb = '0;
    endtask

    task automatic monitor();
        bit g0, g1, rv;
        if (!i_rst) begin
            if (rst_prev) model_reset();
            if (m_busy && m_resolved && cyc > m_rsp_cyc) m_busy = 1'b0;
            g0 = !m_busy && drv0.v && (!drv1.v || m_last);
            g1 = !m_busy && drv1.v && (!drv0.v || !m_last);
            if (m_busy && !m_resolved) begin
                if (gfau_done && cyc >= m_acc + 2 && cyc <= m_acc + 1 + TO) begin
                    m_resolved = 1'b1; m_rsp_cyc = cyc + 1; m_val = gf_f(m_op, m_a, m_b); m_err = 1'b0;
                end else if (cyc == m_acc + 1 + TO) begin
                    m_resolved = 1'b1; m_rsp_cyc = cyc + 1; m_val = '0; m_err = 1'b1;
                end
            end
            rv = m_busy && m_resolved && cyc == m_rsp_cyc;
            if (rv) m_res = m_val;
            chk("ready0", 32'(req0_ready), 32'(g0));
            chk("ready1", 32'(req1_ready), 32'(g1));
            chk("start", 32'(gfau_start), 32'(m_busy && cyc == m_acc + 1));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(rv && !m_who));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(rv && m_who));
            chk("rsp0_err", 32'(rsp0_err), 32'(rv && !m_who && m_err));
            chk("rsp1_err", 32'(rsp1_err), 32'(rv && m_who && m_err));
            chk("rsp_result", rsp_result, m_res);
            chk("owner", 32'(owner), 32'(m_last));
            chk("gfau_op", 32'(gfau_op), 32'(m_gop));
            chk("gfau_in0", gfau_in0, m_ga);
            chk("gfau_in1", gfau_in1, m_gb);
            // GFAU stand-in: schedule completion L cycles after the start it sees
            if (gfau_start) begin
                g_res   = gf_f(gfau_op, gfau_in0, gfau_in1);
                done_at = g_never ? -1 : cyc + g_lat;
            end
            if (req0_ready && drv0.v) begin acc_cnt++; last_acc_cyc = cyc; last_acc_who = 1'b0; end
            if (req1_ready && drv1.v) begin acc_cnt++; last_acc_cyc = cyc; last_acc_who = 1'b1; end
            if (rsp0_valid || rsp1_valid) begin
                rsp_cnt++; last_rsp_cyc = cyc; last_rsp_who = rsp1_valid;
                last_rsp_err = rsp0_err | rsp1_err; last_rsp_val = rsp_result;
            end
            if (g0 || g1) begin
                m_busy = 1'b1; m_resolved = 1'b0; m_acc = cyc; m_who = g1; m_last = g1;
                m_op = g1 ? drv1.op : drv0.op;
                m_a  = g1 ? drv1.a  : drv0.a;
                m_b  = g1 ? drv1.b  : drv0.b;
                m_gop = m_op; m_ga = m_a; m_gb = m_b;
            end
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
        cyc++;
        rst_prev   = i_rst;
        i_rst      = rst_drv;
        req0_valid = drv0.v; req0_op = drv0.op; req0_in0 = drv0.a; req0_in1 = drv0.b;
        req1_valid = drv1.v; req1_op = drv1.op; req1_in0 = drv1.a; req1_in1 = drv1.b;
        gfau_done   = (cyc == done_at) || inject;
        gfau_result = g_res;
        if (rst_drv) done_at = -1;
        @(negedge i_clk);
        monitor();
    endtask

    task automatic run_op(input bit who, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit never, output int acc_c, output int rsp_c);
        int n0, n1;
        g_lat = lat; g_never = never;
        n0 = acc_cnt; n1 = rsp_cnt;
        if (who) drv1 = '{v:1'b1, op:op, a:a, b:b};
        else     drv0 = '{v:1'b1, op:op, a:a, b:b};
        for (int i = 0; i < 20 && acc_cnt == n0; i++) cycle();
        drv0.v = 1'b0; drv1.v = 1'b0;
        chk("op_accepted", 32'(acc_cnt != n0), 32'd1);
        for (int i = 0; i < 40 && rsp_cnt == n1; i++) cycle();
        chk("op_responded", 32'(rsp_cnt != n1), 32'd1);
        acc_c = last_acc_cyc; rsp_c = last_rsp_cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int   acc_c, rsp_c, n, k, prev;
        int   wins[6], accs[6];

        drv0 = '{v:1'b0, op:2'b00, a:32'h0, b:32'h0};
        drv1 = drv0;
        rst_drv = 1'b1; rst_prev = 1'b1; cyc = 0; done_at = -1; g_lat = 1; g_never = 1'b0;
        inject = 1'b0; g_res = '0; total = 0; bad = 0; acc_cnt = 0; rsp_cnt = 0;
        model_reset();

        vt[0] = '{who:1'b0, op:2'b10, a:32'h5, b:32'h7, lat:3, never:1'b0, exp_val:32'h23, exp_err:1'b0, exp_lat:5};
        vt[1] = '{who:1'b1, op:2'b00, a:32'hFFFFFFFF, b:32'h2, lat:1, never:1'b0, exp_val:32'h1, exp_err:1'b0, exp_lat:3};
        vt[2] = '{who:1'b0, op:2'b01, a:32'h3, b:32'h5, lat:16, never:1'b0, exp_val:32'hFFFFFFFE, exp_err:1'b0, exp_lat:18};
        vt[3] = '{who:1'b1, op:2'b00, a:32'h1, b:32'h2, lat:1, never:1'b1, exp_val:32'h0, exp_err:1'b1, exp_lat:18};
        vt[4] = '{who:1'b0, op:2'b11, a:32'h0F0F0000, b:32'h9, lat:17, never:1'b0, exp_val:32'h0, exp_err:1'b1, exp_lat:18};
        vt[5] = '{who:1'b1, op:2'b01, a:32'hA, b:32'h4, lat:2, never:1'b0, exp_val:32'h6, exp_err:1'b0, exp_lat:4};
        vt[6] = '{who:1'b0, op:2'b10, a:32'h10001, b:32'h10001, lat:1, never:1'b0, exp_val:32'h00020001, exp_err:1'b0, exp_lat:3};

        cycle(); cycle();
        rst_drv = 1'b0;
        cycle();
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", rsp_result, 32'd0);

        // directed single operations, including watchdog and done-at-deadline
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].who, vt[i].op, vt[i].a, vt[i].b, vt[i].lat, vt[i].never, acc_c, rsp_c);
            chk("tbl_who", 32'(last_rsp_who), 32'(vt[i].who));
            chk("tbl_val", last_rsp_val, vt[i].exp_val);
            chk("tbl_err", 32'(last_rsp_err), 32'(vt[i].exp_err));
            chk("tbl_latency", 32'(rsp_c - acc_c), 32'(vt[i].exp_lat));
            cycle();
        end

        // contention straight after reset, then continuous contention for fairness
        rst_drv = 1'b1; cycle(); rst_drv = 1'b0;
        g_lat = 2; g_never = 1'b0;
        drv0 = '{v:1'b1, op:2'b00, a:32'h11, b:32'h22};
        drv1 = '{v:1'b1, op:2'b01, a:32'h33, b:32'h44};
        n = rsp_cnt; k = 0; prev = acc_cnt;
        for (int i = 0; i < 6; i++) begin wins[i] = 9; accs[i] = 0; end
        for (int i = 0; i < 120 && k < 6; i++) begin
            cycle();
            if (acc_cnt != prev) begin
                wins[k] = 32'(last_acc_who); accs[k] = last_acc_cyc; k++; prev = acc_cnt;
                if (last_acc_who) drv1.a = $urandom; else drv0.a = $urandom;
            end
        end
        drv0.v = 1'b0; drv1.v = 1'b0;
        chk("rr_count", 32'(k), 32'd6);
        for (int j = 0; j < 6; j++) chk("rr_grant", 32'(wins[j]), 32'(j % 2));
        chk("rr_gap", 32'(accs[1] - accs[0]), 32'd5);
        for (int i = 0; i < 20 && rsp_cnt < n + 6; i++) cycle();
        chk("rr_responses", 32'(rsp_cnt - n), 32'd6);

        // reset while waiting for done
        g_lat = 10;
        drv0 = '{v:1'b1, op:2'b10, a:32'h3, b:32'h4};
        prev = acc_cnt;
        for (int i = 0; i < 10 && acc_cnt == prev; i++) cycle();
        drv0.v = 1'b0;
        n = rsp_cnt;
        cycle(); cycle();
        rst_drv = 1'b1; cycle(); rst_drv = 1'b0;
        cycle();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd1);
        for (int i = 0; i < 14; i++) cycle();
        chk("midrst_no_rsp", 32'(rsp_cnt - n), 32'd0);
        run_op(1'b0, 2'b00, 32'h1, 32'h1, 2, 1'b0, acc_c, rsp_c);
        chk("midrst_after_val", last_rsp_val, 32'h2);
        chk("midrst_after_err", 32'(last_rsp_err), 32'd0);

        // spurious done in IDLE and coincident with start
        cycle();
        n = rsp_cnt;
        inject = 1'b1; cycle(); inject = 1'b0; cycle();
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_rsp", 32'(rsp_cnt - n), 32'd0);
        g_lat = 3;
        drv0 = '{v:1'b1, op:2'b01, a:32'h9, b:32'h2};
        prev = acc_cnt;
        cycle();
        chk("spur_accept", 32'(acc_cnt - prev), 32'd1);
        drv0.v = 1'b0;
        inject = 1'b1; cycle(); inject = 1'b0;
        chk("spur_start", 32'(gfau_start), 32'd1);
        for (int i = 0; i < 20 && rsp_cnt == n; i++) cycle();
        chk("spur_latency", 32'(last_rsp_cyc - last_acc_cyc), 32'd5);
        chk("spur_val", last_rsp_val, 32'h7);
        chk("spur_err", 32'(last_rsp_err), 32'd0);

        // random traffic with random GFAU latency, hangs and occasional resets
        for (int i = 0; i < 600; i++) begin
            drv0.v = ($urandom_range(0, 3) != 0); drv0.op = 2'($urandom); drv0.a = $urandom; drv0.b = $urandom;
            drv1.v = ($urandom_range(0, 2) != 0); drv1.op = 2'($urandom); drv1.a = $urandom; drv1.b = $urandom;
            g_lat   = $urandom_range(1, 18);
            g_never = ($urandom_range(0, 9) == 0);
            rst_drv = ($urandom_range(0, 199) == 0);
            cycle();
        end
        drv0.v = 1'b0; drv1.v = 1'b0; rst_drv = 1'b0;
        for (int i = 0; i < 25; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
